lz77_decoder: RTL
=================

# lz77_decoder

LZ77 decoder that is the receive-side counterpart of the team's LZ77 encoder: it consumes (offset, match_len, char_nxt) code triples and regenerates the original character stream, one character per cycle. It holds a 9-entry sliding search buffer of previously decoded characters, expands back-references, including overlapping ones, and signals end of stream when the `$` terminator (8'h24) arrives as the literal.

## Interface
- `SEARCH_DEPTH`, default 9: search-buffer entries; valid offsets are 0..SEARCH_DEPTH-1.
- `OFF_W`, default 4: offset field width.
- `LEN_W`, default 3: match-length field width; maximum length is 7.
- `TERM_CHAR`, default 8'h24: terminator literal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `code_valid` in 1: code triple present.
- `code_ready` out 1: decoder can accept a triple.
- `code_offset` in OFF_W: back-reference distance; 0 is the most recently decoded char.
- `code_len` in LEN_W: number of chars to copy.
- `code_char` in 8: literal following the copy.
- `out_valid` out 1: `char_out` is valid this cycle.
- `char_out` out 8: decoded character.
- `encode` out 1: tied to 0 (decode mode).
- `finish` out 1: sticky end-of-stream flag.

## Operation
- The search buffer `buf[0..SEARCH_DEPTH-1]` holds 8-bit chars; `buf[0]` is the newest.
- Each emitted char shifts in: `buf[0]` gets the char and `buf[i]` gets `buf[i-1]`.
- IDLE: `code_ready`=1.
  - On `code_valid & code_ready`, latch offset, len and char.
  - Go to COPY if len≠0, else to LIT.
- COPY:
  - Each cycle: `char_out`←`buf[off]`, `out_valid`←1, shift that char in, len←len-1.
  - When len reaches 1, go to LIT.
  - The offset stays fixed, so overlapping copies (len > off+1) replicate correctly.
- LIT:
  - If char≠TERM_CHAR: `char_out`←char, `out_valid`←1, shift it in, go to IDLE.
  - If char=TERM_CHAR: no output, `finish`←1, go to DONE.
- DONE: `code_ready`=0 and `out_valid`=0. Held until reset; further `code_valid` is ignored.
- Offset ≥ SEARCH_DEPTH reads 8'h00.
- Buffer entries never written since reset read 8'h00.
- Only one triple is in flight at a time; there is no input buffering.

## Timing
- Reset values: state IDLE, `code_ready`=1, `out_valid`=0, `char_out`=8'h00, `finish`=0, `encode`=0, all `buf` entries = 8'h00.
- Reset asserted mid-operation aborts immediately: the partial copy is discarded and the buffer is cleared.
- Handshake at edge k:
  - Copied chars are registered at edges k+1..k+L, so `out_valid` is high in the cycles after those edges.
  - The literal is registered at edge k+L+1.
  - `code_ready` returns high after edge k+L+1.
  - The earliest next handshake is edge k+L+2, so each triple costs L+2 cycles.
- `code_ready` is low throughout COPY and LIT. A held `code_valid` is not re-accepted.
- `out_valid` is a registered single-cycle pulse per char. There is no output backpressure.
- Terminator with L>0: the L copied chars are emitted first, then `finish` rises at edge k+L+1 with no `out_valid` on that edge.

## Configuration
- `LZ77_DEC_ERR_EN` defined:
  - Adds output port `err` (1 bit, reset 0).
  - `err` is set sticky on acceptance of a triple whose offset ≥ SEARCH_DEPTH.
  - `err` is also set when `code_valid` is high while in DONE.
  - Decoding continues unchanged.
- Not defined: no `err` port; out-of-range offsets silently read 8'h00.

## Test plan
- Reset: drive `reset`=0 mid-stream, then release → all outputs at reset values and `buf` cleared; the next code (0,0,'A') outputs 8'h41 one cycle after the handshake.
- Literals: codes (0,0,'a'), (0,0,'b') → `char_out` 8'h61 then 8'h62; two `out_valid` pulses, 2 cycles per code.
- Overlap copy: after 'a','b', code (1,4,'c') → chars a,b,a,b,c on 5 consecutive cycles; `code_ready` low for those cycles.
- Terminator: code (0,2,'$') after 'x','y' → outputs y,y, then `finish`=1 with no third `out_valid`; `code_ready` stays 0 afterwards despite `code_valid`=1.
- Backpressure: `code_valid` held high across a len-7 copy → exactly one acceptance; 8 chars out; next acceptance 9 cycles after the first.
- Error (`LZ77_DEC_ERR_EN`): code (9,0,'z') → `err`=1 and the literal 'z' is still output. With (9,2,'z') → two 8'h00 chars, then 'z'.

Source files
------------

// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 code-triple decoder with sliding search buffer; LZ77_DEC_ERR_EN adds sticky err output
module lz77_decoder #(
    parameter int          SEARCH_DEPTH = 9,
    parameter int          OFF_W        = 4,
    parameter int          LEN_W        = 3,
    parameter logic [7:0]  TERM_CHAR    = 8'h24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [OFF_W-1:0] code_offset,
    input  logic [LEN_W-1:0] code_len,
    input  logic [7:0]       code_char,
    output logic             out_valid,
    output logic [7:0]       char_out,
    output logic             encode,
    output logic             finish
`ifdef LZ77_DEC_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_LIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] off_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       char_q;
    logic [7:0]       search_buf [SEARCH_DEPTH];
    logic [7:0]       copy_char;
    logic             shift_en;
    logic [7:0]       shift_char;

    assign encode = 1'b0;

    // Out-of-range offsets fall through to 8'h00.
    always_comb begin
        copy_char = 8'h00;
        for (int i = 0; i < SEARCH_DEPTH; i++) begin
            if (int'(off_q) == i) begin
                copy_char = search_buf[i];
            end
        end
    end

    always_comb begin
        shift_en   = 1'b0;
        shift_char = 8'h00;
        if (state == S_COPY) begin
            shift_en   = 1'b1;
            shift_char = copy_char;
        end else if (state == S_LIT && char_q != TERM_CHAR) begin
            shift_en   = 1'b1;
            shift_char = char_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                search_buf[i] <= 8'h00;
            end
        end else if (shift_en) begin
            search_buf[0] <= shift_char;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                search_buf[i] <= search_buf[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            code_ready <= 1'b1;
            out_valid  <= 1'b0;
            char_out   <= 8'h00;
            finish     <= 1'b0;
            off_q      <= '0;
            len_q      <= '0;
            char_q     <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (code_valid) begin
                        off_q      <= code_offset;
                        len_q      <= code_len;
                        char_q     <= code_char;
                        code_ready <= 1'b0;
                        state      <= (code_len != '0) ? S_COPY : S_LIT;
                    end
                end
                // Offset is held constant, so overlapping copies re-read freshly shifted chars.
                S_COPY: begin
                    char_out  <= copy_char;
                    out_valid <= 1'b1;
                    len_q     <= len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state <= S_LIT;
                    end
                end
                S_LIT: begin
                    if (char_q != TERM_CHAR) begin
                        char_out   <= char_q;
                        out_valid  <= 1'b1;
                        code_ready <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    code_ready <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LZ77_DEC_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (code_valid &&
                     ((state == S_IDLE && int'(code_offset) >= SEARCH_DEPTH) ||
                      state == S_DONE)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
